// File: rtl/fb_bus_pkg.sv
// Shared constants and helpers for the FreeDM bus slave receive path.
package fb_bus_pkg;

  localparam logic [3:0] SOC_NIBBLE = 4'hD;
  localparam int         DEF_NIB_W  = 16;
  localparam int         DEF_ADDR_W = 8;

  // Width of an index counting 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_sat_counter.sv
// Generic clear/increment counter; SATURATE=1 holds at all-ones, 0 wraps.
module fb_sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             max
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign max = &cnt_q;
  assign cnt = cnt_q;

  // NOTE: cnt_d gets a default first so no path through this block infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !(SATURATE && max))
      cnt_d = cnt_q + WIDTH'(1);
  end

  // NOTE: state flops use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fb_rx_frame_counters.sv
// Nibble, byte, slave-index and RAM-address counter bank for the bus slave
// receive path; flags are combinational from the counters and current strobes.
module fb_rx_frame_counters
  import fb_bus_pkg::*;
#(
  parameter  int NIB_W          = DEF_NIB_W,
  parameter  int ADDR_W         = DEF_ADDR_W,
  parameter  int NUM_SLAVES     = 4,
  parameter  int SLAVE_CRC_NIBS = 2,
  parameter  int FRM_CRC_NIBS   = 2,
  localparam int SLV_W          = idx_w(NUM_SLAVES)
) (
  input  logic              MRxClk,
  input  logic              Reset,
  input  logic              StateIdle,
  input  logic              StatePreamble,
  input  logic              StateData,
  input  logic              StateSlaveCrc,
  input  logic              StateFrmCrc,
  input  logic [1:0]        StateSlaveData,
  input  logic              MRxDV,
  input  logic              MRxDEqDataSoC,
  input  logic              RxValid,
  input  logic [NIB_W-1:0]  SlaveDataLen,
  output logic [NIB_W-1:0]  TotalNibCnt,
  output logic [NIB_W-1:0]  NibCnt,
  output logic [NIB_W-1:0]  SlaveByteCnt,
  output logic [SLV_W-1:0]  SlaveIdx,
  output logic [ADDR_W-1:0] TxRamAddr,
  output logic [ADDR_W-1:0] RxRamAddr,
  output logic              SlaveDataEnd,
  output logic              SlaveCrcEnd,
  output logic              FrmCrcStateEnd,
  output logic              LastSlave,
  output logic              SlaveByteCntEq0,
  output logic              TotalNibCntMax,
  output logic              IncrementTotalNibCnt
);

  localparam int CRC_W  = idx_w(SLAVE_CRC_NIBS);
  localparam int FCRC_W = idx_w(FRM_CRC_NIBS);

  logic              sd;
  logic              byte_clr;
  logic              addr_clr;
  logic [NIB_W-1:0]  data_len_m1;
  logic [CRC_W-1:0]  crc_nib_cnt;
  logic [FCRC_W-1:0] frm_crc_nib_cnt;
  logic [5:0]        unused_max;

  assign sd                   = |StateSlaveData;
  assign IncrementTotalNibCnt = StatePreamble | StateData | sd | StateSlaveCrc;
  assign addr_clr             = StateIdle | StatePreamble | StateData;
  assign byte_clr             = (MRxDV & StatePreamble & MRxDEqDataSoC) | StateData;
  // A zero length is treated as a single-nibble slave.
  assign data_len_m1 = (SlaveDataLen == '0) ? '0 : SlaveDataLen - NIB_W'(1);

  fb_sat_counter #(.WIDTH(NIB_W), .SATURATE(1'b1)) u_nib_cnt (
    .clk(MRxClk), .rst(Reset), .clr(StateIdle | StateData), .inc(sd),
    .cnt(NibCnt), .max(unused_max[0])
  );

  fb_sat_counter #(.WIDTH(NIB_W), .SATURATE(1'b1)) u_total_nib_cnt (
    .clk(MRxClk), .rst(Reset), .clr(StateIdle), .inc(IncrementTotalNibCnt),
    .cnt(TotalNibCnt), .max(TotalNibCntMax)
  );

  fb_sat_counter #(.WIDTH(CRC_W), .SATURATE(1'b1)) u_crc_nib_cnt (
    .clk(MRxClk), .rst(Reset), .clr(sd | StateIdle), .inc(StateSlaveCrc),
    .cnt(crc_nib_cnt), .max(unused_max[1])
  );

  fb_sat_counter #(.WIDTH(FCRC_W), .SATURATE(1'b1)) u_frm_crc_nib_cnt (
    .clk(MRxClk), .rst(Reset), .clr(~StateFrmCrc), .inc(StateFrmCrc),
    .cnt(frm_crc_nib_cnt), .max(unused_max[2])
  );

  // Gating the increment with LastSlave saturates at NUM_SLAVES-1 even when
  // that is not a power of two.
  fb_sat_counter #(.WIDTH(SLV_W), .SATURATE(1'b1)) u_slave_idx (
    .clk(MRxClk), .rst(Reset), .clr(StateIdle | StatePreamble),
    .inc(SlaveCrcEnd & ~LastSlave), .cnt(SlaveIdx), .max(unused_max[3])
  );

  fb_sat_counter #(.WIDTH(ADDR_W), .SATURATE(1'b0)) u_tx_ram_addr (
    .clk(MRxClk), .rst(Reset), .clr(addr_clr), .inc(StateSlaveData[0]),
    .cnt(TxRamAddr), .max(unused_max[4])
  );

  fb_sat_counter #(.WIDTH(ADDR_W), .SATURATE(1'b0)) u_rx_ram_addr (
    .clk(MRxClk), .rst(Reset), .clr(addr_clr), .inc(RxValid),
    .cnt(RxRamAddr), .max(unused_max[5])
  );

  fb_sat_counter #(.WIDTH(NIB_W), .SATURATE(1'b1)) u_slave_byte_cnt (
    .clk(MRxClk), .rst(Reset), .clr(byte_clr),
    .inc(MRxDV & StateSlaveData[1] & ~byte_clr),
    .cnt(SlaveByteCnt), .max()
  );

  assign SlaveDataEnd    = sd & (NibCnt == data_len_m1);
  assign SlaveCrcEnd     = StateSlaveCrc & (crc_nib_cnt == CRC_W'(SLAVE_CRC_NIBS - 1));
  assign FrmCrcStateEnd  = StateFrmCrc & (frm_crc_nib_cnt == FCRC_W'(FRM_CRC_NIBS - 1));
  assign LastSlave       = (SlaveIdx == SLV_W'(NUM_SLAVES - 1));
  assign SlaveByteCntEq0 = (SlaveByteCnt == '0);

endmodule

// File: tb/tb_fb_rx_frame_counters.sv
// Directed bench for fb_rx_frame_counters: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fb_rx_frame_counters;

  typedef enum int {
    S_NIB, S_TOT, S_BYTE, S_IDX, S_TX, S_RX,
    S_SDE, S_SCE, S_FCE, S_LAST, S_EQ0, S_TMAX, S_INCT
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        MRxClk = 1'b0;
  logic        Reset;
  logic        StateIdle, StatePreamble, StateData, StateSlaveCrc, StateFrmCrc;
  logic [1:0]  StateSlaveData;
  logic        MRxDV, MRxDEqDataSoC, RxValid;
  logic [15:0] SlaveDataLen;
  logic [15:0] TotalNibCnt, NibCnt, SlaveByteCnt;
  logic [1:0]  SlaveIdx;
  logic [7:0]  TxRamAddr, RxRamAddr;
  logic        SlaveDataEnd, SlaveCrcEnd, FrmCrcStateEnd, LastSlave;
  logic        SlaveByteCntEq0, TotalNibCntMax, IncrementTotalNibCnt;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 MRxClk = ~MRxClk;

  fb_rx_frame_counters dut (
    .MRxClk(MRxClk), .Reset(Reset),
    .StateIdle(StateIdle), .StatePreamble(StatePreamble), .StateData(StateData),
    .StateSlaveCrc(StateSlaveCrc), .StateFrmCrc(StateFrmCrc),
    .StateSlaveData(StateSlaveData), .MRxDV(MRxDV), .MRxDEqDataSoC(MRxDEqDataSoC),
    .RxValid(RxValid), .SlaveDataLen(SlaveDataLen),
    .TotalNibCnt(TotalNibCnt), .NibCnt(NibCnt), .SlaveByteCnt(SlaveByteCnt),
    .SlaveIdx(SlaveIdx), .TxRamAddr(TxRamAddr), .RxRamAddr(RxRamAddr),
    .SlaveDataEnd(SlaveDataEnd), .SlaveCrcEnd(SlaveCrcEnd),
    .FrmCrcStateEnd(FrmCrcStateEnd), .LastSlave(LastSlave),
    .SlaveByteCntEq0(SlaveByteCntEq0), .TotalNibCntMax(TotalNibCntMax),
    .IncrementTotalNibCnt(IncrementTotalNibCnt)
  );

  function automatic logic [31:0] get(input sig_e s);
    case (s)
      S_NIB:   return 32'(NibCnt);
      S_TOT:   return 32'(TotalNibCnt);
      S_BYTE:  return 32'(SlaveByteCnt);
      S_IDX:   return 32'(SlaveIdx);
      S_TX:    return 32'(TxRamAddr);
      S_RX:    return 32'(RxRamAddr);
      S_SDE:   return 32'(SlaveDataEnd);
      S_SCE:   return 32'(SlaveCrcEnd);
      S_FCE:   return 32'(FrmCrcStateEnd);
      S_LAST:  return 32'(LastSlave);
      S_EQ0:   return 32'(SlaveByteCntEq0);
      S_TMAX:  return 32'(TotalNibCntMax);
      default: return 32'(IncrementTotalNibCnt);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every negedge the DUT outputs are settled; compare all queued items.
  always @(negedge MRxClk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, get(e.sig), e.val);
    end
  end

  task automatic push_exp(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge MRxClk);
    #1;
  endtask

  task automatic clr_in();
    StateIdle = 1'b0; StatePreamble = 1'b0; StateData = 1'b0;
    StateSlaveCrc = 1'b0; StateFrmCrc = 1'b0; StateSlaveData = 2'b00;
    MRxDV = 1'b0; MRxDEqDataSoC = 1'b0; RxValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    clr_in();
    SlaveDataLen = 16'd4;
    #2;
    push_exp(S_NIB, 0, "rst_nib");   push_exp(S_TOT, 0, "rst_tot");
    push_exp(S_BYTE, 0, "rst_byte"); push_exp(S_IDX, 0, "rst_idx");
    push_exp(S_TX, 0, "rst_tx");     push_exp(S_RX, 0, "rst_rx");
    push_exp(S_EQ0, 1, "rst_eq0");   push_exp(S_LAST, 0, "rst_last");
    push_exp(S_SDE, 0, "rst_sde");   push_exp(S_SCE, 0, "rst_sce");
    push_exp(S_FCE, 0, "rst_fce");   push_exp(S_TMAX, 0, "rst_tmax");
    push_exp(S_INCT, 0, "rst_inct");
    tick();
    Reset = 1'b0;

    // Mid-count reset: NibCnt=5, RxRamAddr=0x33, then asynchronous Reset.
    RxValid = 1'b1;
    repeat (46) tick();
    StateSlaveData = 2'b10;
    repeat (5) tick();
    clr_in();
    push_exp(S_NIB, 5, "pre_rst_nib");
    push_exp(S_RX, 8'h33, "pre_rst_rx");
    tick();
    Reset = 1'b1;
    push_exp(S_NIB, 0, "mid_rst_nib"); push_exp(S_RX, 0, "mid_rst_rx");
    push_exp(S_TOT, 0, "mid_rst_tot"); push_exp(S_EQ0, 1, "mid_rst_eq0");
    tick();
    Reset = 1'b0;

    // Four-slave frame.
    StatePreamble = 1'b1;
    push_exp(S_INCT, 1, "inct_preamble");
    tick(); tick();
    StatePreamble = 1'b0; StateData = 1'b1;
    tick();
    StateData = 1'b0;
    for (int s = 0; s < 4; s++) begin
      StateSlaveData = 2'b01;
      for (int i = 0; i < 4; i++) begin
        if (s == 0) begin
          push_exp(S_NIB, 32'(i), $sformatf("s0_nib%0d", i));
          push_exp(S_SDE, (i == 3) ? 1 : 0, $sformatf("s0_sde%0d", i));
          push_exp(S_TOT, 32'(3 + i), $sformatf("s0_tot%0d", i));
        end
        if (i == 0) begin
          push_exp(S_IDX, 32'(s), $sformatf("idx_slave%0d", s));
          push_exp(S_LAST, (s == 3) ? 1 : 0, $sformatf("last_slave%0d", s));
        end
        tick();
      end
      StateSlaveData = 2'b00; StateSlaveCrc = 1'b1;
      for (int c = 0; c < 2; c++) begin
        push_exp(S_SCE, (c == 1) ? 1 : 0, $sformatf("sce_s%0d_c%0d", s, c));
        tick();
      end
      StateSlaveCrc = 1'b0;
    end

    // Frame CRC, then Idle.
    StateFrmCrc = 1'b1;
    push_exp(S_TOT, 27, "tot_at_frmcrc"); push_exp(S_TX, 16, "tx_at_frmcrc");
    push_exp(S_IDX, 3, "idx_saturated"); push_exp(S_INCT, 0, "inct_frmcrc");
    push_exp(S_FCE, 0, "fce_cycle1");
    tick();
    push_exp(S_FCE, 1, "fce_cycle2");
    tick();
    StateFrmCrc = 1'b0; StateIdle = 1'b1;
    push_exp(S_FCE, 0, "fce_after"); push_exp(S_TOT, 27, "tot_hold_idle");
    tick();
    StateIdle = 1'b0;
    push_exp(S_TOT, 0, "tot_idle_clr"); push_exp(S_IDX, 0, "idx_idle_clr");
    push_exp(S_LAST, 0, "last_idle_clr"); push_exp(S_TX, 0, "tx_idle_clr");
    tick();

    // Clear/increment collision on RxRamAddr.
    RxValid = 1'b1;
    repeat (3) tick();
    StateData = 1'b1;
    push_exp(S_RX, 3, "rx_before_collide");
    tick();
    clr_in();
    push_exp(S_RX, 0, "rx_collide_clear_wins");
    tick();

    // RxRamAddr wraps modulo 256.
    RxValid = 1'b1;
    repeat (260) tick();
    RxValid = 1'b0;
    push_exp(S_RX, 4, "rx_wrap");
    tick();

    // Byte counter: SoC clear (colliding with increment), then three bytes.
    StateSlaveData = 2'b10; MRxDV = 1'b1;
    tick(); tick();
    clr_in();
    push_exp(S_BYTE, 2, "byte_pre_soc"); push_exp(S_EQ0, 0, "eq0_pre_soc");
    tick();
    StatePreamble = 1'b1; MRxDEqDataSoC = 1'b1; MRxDV = 1'b1; StateSlaveData = 2'b10;
    tick();
    StatePreamble = 1'b0; MRxDEqDataSoC = 1'b0;
    push_exp(S_BYTE, 0, "byte_soc_clr"); push_exp(S_EQ0, 1, "eq0_soc_clr");
    repeat (3) tick();
    clr_in();
    push_exp(S_BYTE, 3, "byte_three"); push_exp(S_EQ0, 0, "eq0_three");
    tick();

    // NibCnt / TotalNibCnt saturation; zero length behaves as length 1.
    StateIdle = 1'b1;
    tick();
    StateIdle = 1'b0;
    SlaveDataLen = 16'd0;
    StateSlaveData = 2'b10;
    push_exp(S_NIB, 0, "nib_sat_start"); push_exp(S_SDE, 1, "sde_len0");
    repeat (65540) tick();
    push_exp(S_NIB, 16'hFFFF, "nib_saturated"); push_exp(S_TOT, 16'hFFFF, "tot_saturated");
    push_exp(S_TMAX, 1, "tot_max_flag"); push_exp(S_SDE, 0, "sde_len0_sat");
    tick();
    clr_in();
    push_exp(S_NIB, 16'hFFFF, "nib_sat_hold");
    tick();
    tick();

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
